// File: rtl/regfile_sb.sv
// Register file with two bypassed combinational read ports, E/M write ports,
// and a per-register in-flight write scoreboard producing decode hazard flags.
module regfile_sb #(
    parameter int DATA_W     = 64,
    parameter int NUM_REGS   = 15,
    parameter int ADDR_W     = 4,
    parameter int CNT_W      = 2,
    parameter int INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              hazA,
    output logic              hazB,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dstE,
    input  logic [ADDR_W-1:0] issue_dstM,
    output logic              issue_ok,
    input  logic              wE_en,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic              wM_en,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              sb_err
);

    logic [DATA_W-1:0]   regs  [NUM_REGS];
    logic [CNT_W-1:0]    count [NUM_REGS];
    logic [NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0] hit_issue;
    logic [NUM_REGS-1:0] inc;
    logic                issue_block;
    logic                underflow;

    // Per-register release/reservation decode and scoreboard limit checks.
    always_comb begin
        dec         = '0;
        hit_issue   = '0;
        issue_block = 1'b0;
        underflow   = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            dec[r]       = (wE_en && dstE == ADDR_W'(r)) || (wM_en && dstM == ADDR_W'(r));
            hit_issue[r] = (issue_dstE == ADDR_W'(r)) || (issue_dstM == ADDR_W'(r));
            if (hit_issue[r] && count[r] == '1 && !dec[r])
                issue_block = 1'b1;
            if (dec[r] && count[r] == '0)
                underflow = 1'b1;
        end
    end

    assign issue_ok = issue_valid && !issue_block;
    assign inc      = {NUM_REGS{issue_ok}} & hit_issue;

    logic              hit_a, hit_b, hit_d;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic [CNT_W-1:0]  cnt_a, cnt_b;
    logic              dec_a, dec_b;

    // Index lookup; a miss means the index is out of range (including RNONE).
    always_comb begin
        hit_a    = 1'b0;
        hit_b    = 1'b0;
        hit_d    = 1'b0;
        rd_a     = '0;
        rd_b     = '0;
        cnt_a    = '0;
        cnt_b    = '0;
        dec_a    = 1'b0;
        dec_b    = 1'b0;
        dbg_data = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (srcA == ADDR_W'(r)) begin
                hit_a = 1'b1;
                rd_a  = regs[r];
                cnt_a = count[r];
                dec_a = dec[r];
            end
            if (srcB == ADDR_W'(r)) begin
                hit_b = 1'b1;
                rd_b  = regs[r];
                cnt_b = count[r];
                dec_b = dec[r];
            end
            if (dbg_addr == ADDR_W'(r)) begin
                hit_d    = 1'b1;
                dbg_data = regs[r];
            end
        end
    end

    always_comb begin
        valA = '0;
        valB = '0;
        if (hit_a)
            valA = (wM_en && dstM == srcA) ? valM :
                   (wE_en && dstE == srcA) ? valE : rd_a;
        if (hit_b)
            valB = (wM_en && dstM == srcB) ? valM :
                   (wE_en && dstE == srcB) ? valE : rd_b;
    end

    assign hazA = hit_a && (cnt_a > CNT_W'(dec_a));
    assign hazB = hit_b && (cnt_b > CNT_W'(dec_b));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                regs[r] <= (INIT_INDEX != 0) ? DATA_W'(r) : '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (wM_en && dstM == ADDR_W'(r))
                    regs[r] <= valM;
                else if (wE_en && dstE == ADDR_W'(r))
                    regs[r] <= valE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                count[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (inc[r] && !dec[r])
                    count[r] <= count[r] + CNT_W'(1);
                else if (!inc[r] && dec[r] && count[r] != '0)
                    count[r] <= count[r] - CNT_W'(1);
            end
            sb_err <= sb_err | underflow | (issue_valid && !issue_ok);
        end
    end

    // A debug index miss leaves dbg_data at zero; hit_d documents that path.
    logic unused_hit_d;
    assign unused_hit_d = hit_d;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a behavioural scoreboard/regfile model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_regfile_sb;

    localparam int NR = 15;
    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  srcA, srcB, issue_dstE, issue_dstM, dstE, dstM, dbg_addr;
    logic [63:0] valA, valB, valE, valM, dbg_data;
    logic        hazA, hazB, issue_valid, issue_ok, wE_en, wM_en, sb_err;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.DATA_W(64), .NUM_REGS(15), .ADDR_W(4), .CNT_W(2), .INIT_INDEX(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB), .hazA(hazA), .hazB(hazB),
        .issue_valid(issue_valid), .issue_dstE(issue_dstE), .issue_dstM(issue_dstM),
        .issue_ok(issue_ok),
        .wE_en(wE_en), .dstE(dstE), .valE(valE),
        .wM_en(wM_en), .dstM(dstM), .valM(valM),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    logic [63:0] m_reg [NR];
    int          m_cnt [NR];
    bit          m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_dec(input int r);
        return (wE_en && int'(dstE) == r) || (wM_en && int'(dstM) == r);
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] src);
        if (int'(src) >= NR) return 64'd0;
        if (wM_en && dstM == src) return valM;
        if (wE_en && dstE == src) return valE;
        return m_reg[src];
    endfunction

    function automatic bit m_haz(input logic [3:0] src);
        if (int'(src) >= NR) return 1'b0;
        return m_cnt[src] > int'(m_dec(int'(src)));
    endfunction

    function automatic bit m_full(input logic [3:0] d);
        if (int'(d) >= NR) return 1'b0;
        return m_cnt[d] == MAXC && !m_dec(int'(d));
    endfunction

    function automatic bit m_ok();
        return issue_valid && !m_full(issue_dstE) && !m_full(issue_dstM);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) begin
                m_reg[r] = 64'(r);
                m_cnt[r] = 0;
            end
            m_err = 1'b0;
        end else begin
            bit ok;
            ok = m_ok();
            if (issue_valid && !ok) m_err = 1'b1;
            for (int r = 0; r < NR; r++) begin
                int n;
                bit inc, dec;
                inc = ok && (int'(issue_dstE) == r || int'(issue_dstM) == r);
                dec = m_dec(r);
                if (dec && m_cnt[r] == 0) m_err = 1'b1;
                n = m_cnt[r] + int'(inc) - int'(dec);
                m_cnt[r] = (n < 0) ? 0 : n;
            end
            if (wE_en && int'(dstE) < NR) m_reg[dstE] = valE;
            if (wM_en && int'(dstM) < NR) m_reg[dstM] = valM;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("valA", valA, m_read(srcA));
        chk("valB", valB, m_read(srcB));
        chk("hazA", 64'(hazA), 64'(m_haz(srcA)));
        chk("hazB", 64'(hazB), 64'(m_haz(srcB)));
        chk("issue_ok", 64'(issue_ok), 64'(m_ok()));
        chk("dbg_data", dbg_data, (int'(dbg_addr) < NR) ? m_reg[dbg_addr] : 64'd0);
        chk("sb_err", 64'(sb_err), 64'(m_err));
    end

    task automatic idle();
        srcA = 4'hF; srcB = 4'hF; dbg_addr = 4'hF;
        issue_valid = 1'b0; issue_dstE = 4'hF; issue_dstM = 4'hF;
        wE_en = 1'b0; dstE = 4'hF; valE = '0;
        wM_en = 1'b0; dstM = 4'hF; valM = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        idle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [3:0] e, input logic [3:0] m);
        issue_valid = 1'b1; issue_dstE = e; issue_dstM = m;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;

        // Reset contents and flags.
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            dbg_addr = 4'(i);
            #1;
            chk("reset_dbg", dbg_data, (i < NR) ? 64'(i) : 64'd0);
        end
        chk("reset_hazA", 64'(hazA), 64'd0);
        chk("reset_hazB", 64'(hazB), 64'd0);
        chk("reset_sb_err", 64'(sb_err), 64'd0);

        // Same-destination E/M write: M wins, visible through bypass.
        next_cycle();
        wE_en = 1'b1; dstE = 4'd3; valE = 64'hAA;
        wM_en = 1'b1; dstM = 4'd3; valM = 64'h55;
        srcA = 4'd3;
        #1;
        chk("prio_valA", valA, 64'h55);
        next_cycle();
        idle();
        dbg_addr = 4'd3;
        #1;
        chk("prio_dbg", dbg_data, 64'h55);
        chk("prio_underflow_err", 64'(sb_err), 64'd1);

        // Reserve then release, plus E-path bypass on port B.
        do_reset();
        next_cycle();
        issue(4'd2, 4'hF);
        #1;
        chk("rsv_ok", 64'(issue_ok), 64'd1);
        next_cycle();
        idle();
        srcA = 4'd2;
        #1;
        chk("rsv_hazA", 64'(hazA), 64'd1);
        next_cycle();
        wE_en = 1'b1; dstE = 4'd2; valE = 64'd7;
        wM_en = 1'b1; dstM = 4'd9; valM = 64'h77;
        srcB = 4'd9;
        #1;
        chk("rel_hazA", 64'(hazA), 64'd0);
        chk("rel_valA", valA, 64'd7);
        chk("bypassM_valB", valB, 64'h77);
        next_cycle();
        idle();
        srcA = 4'd2;
        wE_en = 1'b1; dstE = 4'd8; valE = 64'h1F; srcB = 4'd8;
        #1;
        chk("after_rel_hazA", 64'(hazA), 64'd0);
        chk("after_rel_valA", valA, 64'd7);
        chk("bypassE_valB", valB, 64'h1F);

        // Saturation of a CNT_W=2 counter.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            issue(4'd5, 4'hF);
            #1;
            chk("sat_issue_ok", 64'(issue_ok), 64'd1);
        end
        next_cycle();
        issue(4'd5, 4'd5);
        wE_en = 1'b1; dstE = 4'd5; valE = 64'h5A;
        srcA = 4'd5;
        #1;
        chk("sat_release_ok", 64'(issue_ok), 64'd1);
        chk("sat_release_hazA", 64'(hazA), 64'd1);
        next_cycle();
        idle();
        issue(4'd5, 4'hF);
        #1;
        chk("sat_full_ok", 64'(issue_ok), 64'd0);
        next_cycle();
        idle();
        srcA = 4'd5;
        #1;
        chk("sat_err", 64'(sb_err), 64'd1);
        chk("sat_hazA", 64'(hazA), 64'd1);

        // Underflow on a write with no reservation.
        do_reset();
        next_cycle();
        wE_en = 1'b1; dstE = 4'd6; valE = 64'h1234;
        next_cycle();
        idle();
        dbg_addr = 4'd6; srcA = 4'd6;
        #1;
        chk("uf_dbg", dbg_data, 64'h1234);
        chk("uf_err", 64'(sb_err), 64'd1);
        chk("uf_hazA", 64'(hazA), 64'd0);

        // Asynchronous reset while reg 4 holds pending reservations.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            issue(4'd4, 4'hF);
        end
        next_cycle();
        idle();
        wM_en = 1'b1; dstM = 4'd4; valM = 64'h99;
        next_cycle();
        idle();
        srcA = 4'd4; dbg_addr = 4'd4;
        #1;
        chk("pre_rst_hazA", 64'(hazA), 64'd1);
        chk("pre_rst_dbg", dbg_data, 64'h99);
        rst_n = 1'b0;
        issue(4'd4, 4'hF);
        #1;
        chk("async_hazA", 64'(hazA), 64'd0);
        chk("async_valA", valA, 64'd4);
        chk("async_dbg", dbg_data, 64'd4);
        chk("async_issue_ok", 64'(issue_ok), 64'd1);
        issue_valid = 1'b0;
        rst_n = 1'b1;

        // Mixed traffic against the model.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            next_cycle();
            srcA        = 4'($urandom_range(0, 15));
            srcB        = 4'($urandom_range(0, 15));
            dbg_addr    = 4'($urandom_range(0, 15));
            issue_valid = 1'($urandom_range(0, 1));
            issue_dstE  = 4'($urandom_range(0, 15));
            issue_dstM  = 4'($urandom_range(0, 15));
            wE_en       = 1'($urandom_range(0, 1));
            dstE        = 4'($urandom_range(0, 15));
            valE        = {$urandom, $urandom};
            wM_en       = 1'($urandom_range(0, 1));
            dstM        = 4'($urandom_range(0, 15));
            valM        = {$urandom, $urandom};
            if (k % 100 == 99) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
        end
        next_cycle();
        idle();
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
